// File: rtl/canvas_pkg.sv
// Shared constants, canvas array type and reader FSM states for the canvas
// read path between the drawing editor and the network input stage.
package canvas_pkg;

  localparam int CANVAS_DIM = 28;
  localparam int PIX_W      = 16;
  localparam int MAX_VAL    = 2048;
  localparam int SUM_W      = 21;
  localparam int NUM_PIX    = CANVAS_DIM * CANVAS_DIM;
  localparam int COORD_W    = $clog2(CANVAS_DIM);
  localparam int IDX_W      = $clog2(NUM_PIX);

  // Indexed canvas[x][y], matching the editor's storage layout.
  typedef logic [CANVAS_DIM-1:0][CANVAS_DIM-1:0][PIX_W-1:0] canvas_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } canvas_state_e;

endpackage

// File: rtl/canvas_reader_if.sv
// Pixel stream from the canvas reader to the network input stage
// (valid/ready handshake with index and end-of-canvas flag).
interface canvas_reader_if;
  import canvas_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [IDX_W-1:0] pix_index;
  logic             pix_last;

  modport master (
    output pix_valid, pix_data, pix_index, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_index, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/canvas_addr_counter.sv
// Row-major x/y walker over the canvas. Exposes the coordinate that will be
// current after this edge so the reader can register the matching pixel.
module canvas_addr_counter
  import canvas_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x_nxt,
  output logic [COORD_W-1:0] y_nxt,
  output logic [IDX_W-1:0]   idx_nxt,
  output logic               last_nxt
);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (clear) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (advance) begin
      if (x == COORD_W'(CANVAS_DIM - 1)) begin
        x_nxt = '0;
        y_nxt = y + COORD_W'(1);
      end else begin
        x_nxt = x + COORD_W'(1);
      end
    end
  end

  assign idx_nxt  = IDX_W'(y_nxt) * IDX_W'(CANVAS_DIM) + IDX_W'(x_nxt);
  assign last_nxt = (idx_nxt == IDX_W'(NUM_PIX - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/canvas_reader.sv
// Streams the 28x28 canvas row-major as clamped pixels over valid/ready and
// reports the total clamped intensity of each completed read.
module canvas_reader
  import canvas_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  canvas_t                canvas,
  canvas_reader_if.master        pix,
  output logic                   busy,
  output logic                   done,
  output logic [SUM_W-1:0]       pix_sum
);

  function automatic logic [PIX_W-1:0] clamp_pix(input logic [PIX_W-1:0] v);
    return (v > PIX_W'(MAX_VAL)) ? PIX_W'(MAX_VAL) : v;
  endfunction

  canvas_state_e      state;
  logic               vld_p1;
  logic               last_p1;
  logic [PIX_W-1:0]   data_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [SUM_W-1:0]   acc;

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               last_nxt;
  logic               hs;
  logic               clear;
  logic               advance;

  assign hs      = vld_p1 & pix.pix_ready;
  assign clear   = (state == IDLE) & Start;
  assign advance = (state == STREAM) & hs & ~last_p1;

  canvas_addr_counter u_addr (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (clear),
    .advance  (advance),
    .x_nxt    (x_nxt),
    .y_nxt    (y_nxt),
    .idx_nxt  (idx_nxt),
    .last_nxt (last_nxt)
  );

  // Stage p1: pixel fetched from the upcoming coordinate and held until accepted
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      last_p1 <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pix_sum <= '0;
      acc     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= STREAM;
            vld_p1  <= 1'b1;
            busy    <= 1'b1;
            acc     <= '0;
            data_p1 <= clamp_pix(canvas[x_nxt][y_nxt]);
            idx_p1  <= idx_nxt;
            last_p1 <= last_nxt;
          end
        end
        STREAM: begin
          if (hs) begin
            acc <= acc + SUM_W'(data_p1);
            if (last_p1) begin
              state   <= DONE;
              vld_p1  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pix_sum <= acc + SUM_W'(data_p1);
            end else begin
              data_p1 <= clamp_pix(canvas[x_nxt][y_nxt]);
              idx_p1  <= idx_nxt;
              last_p1 <= last_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pix.pix_valid = vld_p1;
  assign pix.pix_data  = data_p1;
  assign pix.pix_index = idx_p1;
  assign pix.pix_last  = last_p1;

endmodule

// File: tb/tb_canvas_reader.sv
// Directed bench for canvas_reader: reset, empty/sparse/saturated canvases,
// random back-pressure, ignored mid-stream Start and mid-stream reset.
module tb_canvas_reader;
  import canvas_pkg::*;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  canvas_t          canvas = '0;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] pix_sum;

  canvas_reader_if pif ();

  canvas_reader dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .canvas  (canvas),
    .pix     (pif),
    .busy    (busy),
    .done    (done),
    .pix_sum (pix_sum)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic [PIX_W-1:0] got_data [NUM_PIX];
  int               got_idx  [NUM_PIX];
  int               n_got, last_cnt, last_idx, done_cnt, done_cyc, stall_err, busy_err;
  logic [SUM_W-1:0] sum_at_start;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [PIX_W-1:0] model_pix(input int i);
    logic [PIX_W-1:0] v;
    v = canvas[i % CANVAS_DIM][i / CANVAS_DIM];
    return (v > 16'd2048) ? 16'd2048 : v;
  endfunction

  function automatic int data_errors();
    int e = 0;
    for (int i = 0; i < NUM_PIX; i++)
      if (got_data[i] !== model_pix(i)) e++;
    return e;
  endfunction

  function automatic int index_errors();
    int e = 0;
    for (int i = 0; i < NUM_PIX; i++)
      if (got_idx[i] != i) e++;
    return e;
  endfunction

  // Drives one full read and records what the consumer saw.
  task automatic run_read(input int ready_pct, input int restart_at, input int max_cyc);
    int               cyc;
    logic             pv, pr, pl, rdy;
    logic [PIX_W-1:0] pd;
    logic [IDX_W-1:0] pi;
    bit               restarted;
    n_got = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; done_cyc = -1;
    stall_err = 0; busy_err = 0; restarted = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; pi = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      got_data[i] = 'x;
      got_idx[i]  = -1;
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 1;
    sum_at_start = pix_sum;
    while (cyc < max_cyc && (done_cyc < 0 || cyc < done_cyc + 3)) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy || pif.pix_valid) busy_err++;
      end else if ((done_cyc < 0) != busy) begin
        busy_err++;
      end
      if (pv && !pr) begin
        if (!pif.pix_valid || pif.pix_data !== pd || pif.pix_index !== pi || pif.pix_last !== pl)
          stall_err++;
      end
      rdy = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < ready_pct);
      pif.pix_ready = rdy;
      if (pif.pix_valid && rdy) begin
        if (n_got < NUM_PIX) begin
          got_data[n_got] = pif.pix_data;
          got_idx[n_got]  = int'(pif.pix_index);
        end
        if (pif.pix_last) begin
          last_cnt++;
          last_idx = int'(pif.pix_index);
        end
        n_got++;
      end
      if (!restarted && restart_at >= 0 && n_got == restart_at) begin
        Start = 1'b1;
        restarted = 1;
      end
      pv = pif.pix_valid; pr = rdy; pd = pif.pix_data; pi = pif.pix_index; pl = pif.pix_last;
      tick();
      Start = 1'b0;
      cyc++;
    end
    pif.pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    pif.pix_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (pif.pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl valid=%b busy=%b done=%b expected 0 0 0", pif.pix_valid, busy, done);
    end
    checks++;
    if (pif.pix_data !== '0 || pif.pix_index !== '0 || pif.pix_last !== 1'b0 || pix_sum !== '0) begin
      failures++;
      $display("FAIL reset_data data=%0d index=%0d last=%b sum=%0d expected all 0",
               pif.pix_data, pif.pix_index, pif.pix_last, pix_sum);
    end
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    checks++;
    if (pif.pix_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_loses valid=%b busy=%b expected 0 0", pif.pix_valid, busy);
    end
  endtask

  task automatic test_empty();
    canvas = '0;
    run_read(100, -1, 900);
    checks++;
    if (n_got != 784 || data_errors() != 0) begin
      failures++;
      $display("FAIL empty_pixels got=%0d errors=%0d expected 784 0", n_got, data_errors());
    end
    checks++;
    if (index_errors() != 0) begin
      failures++;
      $display("FAIL empty_index errors=%0d expected 0", index_errors());
    end
    checks++;
    if (last_cnt != 1 || last_idx != 783) begin
      failures++;
      $display("FAIL empty_last count=%0d at=%0d expected 1 783", last_cnt, last_idx);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 785) begin
      failures++;
      $display("FAIL empty_done count=%0d cycle=%0d expected 1 785", done_cnt, done_cyc);
    end
    checks++;
    if (pix_sum !== 21'd0 || busy_err != 0) begin
      failures++;
      $display("FAIL empty_sum_busy sum=%0d busy_err=%0d expected 0 0", pix_sum, busy_err);
    end
  endtask

  task automatic test_sparse();
    canvas = '0;
    canvas[3][5]   = 16'd1500;
    canvas[27][27] = 16'd2048;
    run_read(100, -1, 900);
    checks++;
    if (got_data[143] !== 16'd1500 || got_data[783] !== 16'd2048) begin
      failures++;
      $display("FAIL sparse_values idx143=%0d idx783=%0d expected 1500 2048", got_data[143], got_data[783]);
    end
    checks++;
    if (data_errors() != 0) begin
      failures++;
      $display("FAIL sparse_stream errors=%0d expected 0", data_errors());
    end
    checks++;
    if (pix_sum !== 21'd3548) begin
      failures++;
      $display("FAIL sparse_sum got=%0d expected 3548", pix_sum);
    end
  endtask

  task automatic test_clamp();
    canvas = '0;
    canvas[0][0] = 16'd4000;
    run_read(100, -1, 900);
    checks++;
    if (got_data[0] !== 16'd2048 || pix_sum !== 21'd2048) begin
      failures++;
      $display("FAIL clamp_single data=%0d sum=%0d expected 2048 2048", got_data[0], pix_sum);
    end
    for (int x = 0; x < CANVAS_DIM; x++)
      for (int y = 0; y < CANVAS_DIM; y++)
        canvas[x][y] = 16'd4000;
    run_read(100, -1, 900);
    checks++;
    if (sum_at_start !== 21'd2048) begin
      failures++;
      $display("FAIL sum_held_on_start got=%0d expected 2048", sum_at_start);
    end
    checks++;
    if (data_errors() != 0 || got_data[400] !== 16'd2048) begin
      failures++;
      $display("FAIL clamp_all errors=%0d idx400=%0d expected 0 2048", data_errors(), got_data[400]);
    end
    checks++;
    if (pix_sum !== 21'd1605632) begin
      failures++;
      $display("FAIL clamp_sum got=%0d expected 1605632", pix_sum);
    end
  endtask

  task automatic set_diagonal();
    canvas = '0;
    for (int i = 0; i < CANVAS_DIM; i++)
      canvas[i][i] = PIX_W'(i * 50 + 1);
  endtask

  task automatic test_backpressure();
    set_diagonal();
    run_read(50, -1, 5000);
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL stall_stable violations=%0d expected 0", stall_err);
    end
    checks++;
    if (n_got != 784 || index_errors() != 0 || data_errors() != 0) begin
      failures++;
      $display("FAIL stall_order got=%0d idx_err=%0d data_err=%0d expected 784 0 0",
               n_got, index_errors(), data_errors());
    end
    checks++;
    if (got_data[29] !== 16'd51 || pix_sum !== 21'd18928 || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_sum idx29=%0d sum=%0d done=%0d expected 51 18928 1",
               got_data[29], pix_sum, done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    set_diagonal();
    run_read(100, 100, 900);
    checks++;
    if (n_got != 784 || index_errors() != 0 || done_cnt != 1 || done_cyc != 785) begin
      failures++;
      $display("FAIL start_ignored got=%0d idx_err=%0d done=%0d at=%0d expected 784 0 1 785",
               n_got, index_errors(), done_cnt, done_cyc);
    end
    checks++;
    if (pix_sum !== 21'd18928 || busy_err != 0) begin
      failures++;
      $display("FAIL start_ignored_sum sum=%0d busy_err=%0d expected 18928 0", pix_sum, busy_err);
    end
  endtask

  task automatic test_reset_midstream();
    bit reached;
    bit saw_done;
    canvas = '0;
    canvas[0][0] = 16'd77;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    pif.pix_ready = 1'b1;
    reached = 0;
    for (int c = 0; c < 1000 && !reached; c++) begin
      if (pif.pix_valid && pif.pix_index == 10'd400) reached = 1;
      else tick();
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL midreset_reach index=%0d expected 400", pif.pix_index);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (pif.pix_valid !== 1'b0 || busy !== 1'b0 || pif.pix_index !== '0 || pix_sum !== '0) begin
      failures++;
      $display("FAIL midreset_state valid=%b busy=%b index=%0d sum=%0d expected 0 0 0 0",
               pif.pix_valid, busy, pif.pix_index, pix_sum);
    end
    saw_done = (done === 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1 || pif.pix_valid === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midreset_no_done activity=%b expected 0", saw_done);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (pif.pix_valid !== 1'b1 || busy !== 1'b1 || pif.pix_index !== '0 || pif.pix_data !== 16'd77) begin
      failures++;
      $display("FAIL midreset_restart valid=%b busy=%b index=%0d data=%0d expected 1 1 0 77",
               pif.pix_valid, busy, pif.pix_index, pif.pix_data);
    end
    saw_done = 0;
    for (int c = 0; c < 1000 && !saw_done; c++) begin
      tick();
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (!saw_done || pix_sum !== 21'd77) begin
      failures++;
      $display("FAIL midreset_complete done=%b sum=%0d expected 1 77", saw_done, pix_sum);
    end
    pif.pix_ready = 1'b0;
  endtask

  initial begin
    pif.pix_ready = 1'b0;
    test_reset();
    test_empty();
    test_sparse();
    test_clamp();
    test_backpressure();
    test_start_ignored();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
